// File: rtl/aoc3_line_sequencer_if.sv
// aoc3_line_sequencer_if: ASCII byte stream handshake between a byte source and the line sequencer
interface aoc3_line_sequencer_if;
   logic       in_valid;
   logic       in_ready;
   logic       in_last;
   logic [7:0] in_char;
   modport master (output in_valid, output in_last, output in_char, input in_ready);
   modport slave (input in_valid, input in_last, input in_char, output in_ready);
endinterface

// File: rtl/aoc3_line_sequencer.sv
// aoc3_line_sequencer: splits an ASCII digit stream into lines for a selection engine and sums its results; AOC3_LINE_CHECK_EN enables the line-length check
`ifndef DATA_WIDTH
`define DATA_WIDTH 4
`endif
module aoc3_line_sequencer #(
   parameter int LINE_LENGTH = 15,
   parameter int MAX_CAP     = 12,
   parameter int SUM_W       = 64
) (
   input  logic                     clock,
   input  logic                     reset,
   aoc3_line_sequencer_if.slave     stream,
   output logic                     eng_clear,
   output logic                     eng_data_valid,
   output logic [`DATA_WIDTH-1:0]   eng_data,
   output logic                     eng_newline,
   input  logic                     eng_result_valid,
   input  logic [SUM_W-1:0]         eng_result,
   output logic [SUM_W-1:0]         sum,
   output logic                     sum_valid,
   output logic [15:0]              line_count,
   output logic                     busy,
   output logic                     err
);
   localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, STREAM = 3'd2, DRAIN = 3'd3, ACCUM = 3'd4, DONE = 3'd5;
   localparam int CW = $clog2(LINE_LENGTH + 2);
   // an engine that keeps more digits than a line holds can never produce a valid result
   localparam bit CAP_OK = MAX_CAP <= LINE_LENGTH;
   logic [2:0]       state;
   logic [CW-1:0]    dcnt;
   logic [CW-1:0]    dnext;
   logic             last_flag;
   logic [SUM_W-1:0] result;
   logic             take;
   logic             is_digit;
   logic             eol;
   logic             fwd;
   logic             start;
   logic             len_bad;
   assign start    = state == IDLE && stream.in_valid && CAP_OK;
   assign take     = stream.in_valid && stream.in_ready;
   assign is_digit = stream.in_char >= 8'h30 && stream.in_char <= 8'h39;
   assign eol      = take && (stream.in_char == 8'h0a || stream.in_last);
   assign fwd      = take && is_digit && dcnt < CW'(LINE_LENGTH);
   // counter saturates one past LINE_LENGTH so over-long lines stay distinguishable
   assign dnext    = (take && is_digit && dcnt <= CW'(LINE_LENGTH)) ? dcnt + 1'b1 : dcnt;
   assign stream.in_ready = state == STREAM;
   assign eng_clear       = state == CLEAR;
   assign eng_newline     = state == DRAIN && !eng_data_valid;
   assign sum_valid       = state == DONE;
   assign busy            = state != IDLE;
`ifdef AOC3_LINE_CHECK_EN
   logic err_q;
   assign len_bad = dnext != CW'(LINE_LENGTH);
   assign err     = err_q;
   always_ff @(posedge clock) begin
      if (!reset) err_q <= 1'b0;
      else if (start) err_q <= 1'b0;
      else if (state == STREAM && eol && dnext != '0 && len_bad) err_q <= 1'b1;
   end
`else
   assign len_bad = 1'b0;
   assign err     = 1'b0;
`endif
   always_ff @(posedge clock) begin
      if (!reset) begin
         state          <= IDLE;
         dcnt           <= '0;
         last_flag      <= 1'b0;
         result         <= '0;
         sum            <= '0;
         line_count     <= '0;
         eng_data_valid <= 1'b0;
         eng_data       <= '0;
      end else begin
         eng_data_valid <= fwd;
         if (fwd) eng_data <= `DATA_WIDTH'(stream.in_char - 8'h30);
         case (state)
            IDLE: if (start) begin
               sum        <= '0;
               line_count <= '0;
               state      <= CLEAR;
            end
            CLEAR: begin
               dcnt  <= '0;
               state <= STREAM;
            end
            STREAM: begin
               dcnt <= dnext;
               if (eol) begin
                  last_flag <= stream.in_last;
                  state     <= (dnext == '0 || len_bad) ? (stream.in_last ? DONE : CLEAR) : DRAIN;
               end
            end
            DRAIN: if (eng_newline && eng_result_valid) begin
               result <= eng_result;
               state  <= ACCUM;
            end
            ACCUM: begin
               sum        <= sum + result;
               line_count <= line_count + 16'd1;
               state      <= last_flag ? DONE : CLEAR;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_aoc3_line_sequencer.sv
// tb_aoc3_line_sequencer: table vectors, corner sequences and random runs against a line-level reference model
`ifndef DATA_WIDTH
`define DATA_WIDTH 4
`endif
module tb_aoc3_line_sequencer;
   localparam int LL = 15;
   localparam int CAP = 12;
`ifdef AOC3_LINE_CHECK_EN
   localparam bit CHECK = 1'b1;
`else
   localparam bit CHECK = 1'b0;
`endif
   typedef struct {
      string       txt;
      bit          gaps;
      logic [63:0] sum;
      int          lines;
      int          clears;
      int          drains;
      bit          err;
   } vec_t;
   typedef struct {
      logic [63:0] sum;
      int          lines;
      int          clears;
      int          drains;
      int          strobes;
      bit          err;
   } res_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic eng_clear, eng_data_valid, eng_newline, sum_valid, busy, err;
   logic [`DATA_WIDTH-1:0] eng_data;
   logic eng_result_valid = 1'b0;
   logic [63:0] eng_result = '0;
   logic [63:0] sum;
   logic [15:0] line_count;
   int n_chk = 0, n_bad = 0;
   int n_clr = 0, n_dv = 0, n_nl = 0, n_sv = 0;
   int lat = 2;
   int ecnt = 0;
   int eq[$];
   logic nl_d = 1'b0;
   aoc3_line_sequencer_if bus();
   aoc3_line_sequencer dut (
      .clock(clk), .reset(rst_n), .stream(bus.slave),
      .eng_clear(eng_clear), .eng_data_valid(eng_data_valid), .eng_data(eng_data),
      .eng_newline(eng_newline), .eng_result_valid(eng_result_valid), .eng_result(eng_result),
      .sum(sum), .sum_valid(sum_valid), .line_count(line_count), .busy(busy), .err(err)
   );
   always #5 clk = ~clk;
   function automatic logic [63:0] best(input int d[$]);
      int k = d.size() < CAP ? d.size() : CAP;
      int pos = 0;
      logic [63:0] v = '0;
      for (int j = 0; j < k; j++) begin
         int m = pos;
         for (int p = pos; p <= d.size() - (k - j); p++) if (d[p] > d[m]) m = p;
         v = v * 10 + 64'(d[m]);
         pos = m + 1;
      end
      return v;
   endfunction
   function automatic res_t model(input string s);
      res_t r = '{sum: '0, lines: 0, clears: 0, drains: 0, strobes: 0, err: 1'b0};
      int d[$];
      for (int i = 0; i < s.len(); i++) begin
         byte c = s[i];
         bit dig = c >= 8'h30 && c <= 8'h39;
         if (dig) d.push_back(int'(c) - 48);
         if (c == 8'h0a || i == s.len() - 1) begin
            r.clears++;
            if (d.size() > 0) begin
               r.strobes += d.size() < LL ? d.size() : LL;
               if (CHECK && d.size() != LL) r.err = 1'b1;
               else begin
                  while (d.size() > LL) void'(d.pop_back());
                  r.sum += best(d);
                  r.lines++;
                  r.drains++;
               end
            end
            d.delete();
         end
      end
      return r;
   endfunction
   function automatic string gen();
      string s = "";
      int nlines = $urandom_range(1, 4);
      for (int l = 0; l < nlines; l++) begin
         int pick = $urandom_range(0, 5);
         int n = pick == 0 ? 0 : pick == 1 ? 14 : pick == 2 ? 17 : LL;
         for (int k = 0; k < n; k++) s = $sformatf("%s%c", s, 8'h30 + 8'($urandom_range(0, 9)));
         if (l == nlines - 1 && n > 0 && $urandom_range(0, 1) == 1) break;
         if ($urandom_range(0, 3) == 0) s = $sformatf("%s%c", s, 8'h0d);
         s = $sformatf("%s%c", s, 8'h0a);
      end
      return s;
   endfunction
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask
   // engine stand-in: collects forwarded digits, answers a drain after lat cycles, injects stray strobes when no drain can follow
   always @(posedge clk) begin
      if (!rst_n) begin
         eq.delete();
         ecnt <= 0;
         eng_result_valid <= 1'b0;
      end else begin
         eng_result_valid <= 1'b0;
         if (eng_clear) eq.delete();
         if (eng_data_valid) eq.push_back(int'(eng_data));
         if (eng_newline && !eng_result_valid) begin
            if (ecnt >= lat) begin
               eng_result_valid <= 1'b1;
               eng_result <= best(eq);
               ecnt <= 0;
            end else ecnt <= ecnt + 1;
         end else if (!eng_newline) begin
            ecnt <= 0;
            if ((!busy || eng_clear) && $urandom_range(0, 2) == 0) begin
               eng_result_valid <= 1'b1;
               eng_result <= {$urandom, $urandom};
            end
         end
      end
   end
   always @(posedge clk) begin
      if (rst_n) begin
         if (eng_clear) n_clr++;
         if (eng_data_valid) n_dv++;
         if (eng_newline && !nl_d) n_nl++;
         if (sum_valid) n_sv++;
      end
      nl_d <= eng_newline;
   end
   task automatic send(input string s, input bit gaps, input bit fin_last);
      for (int i = 0; i < s.len(); i++) begin
         int t = 0;
         bit ok = 1'b0;
         if (gaps) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
         end
         bus.in_valid = 1'b1;
         bus.in_char = s[i];
         bus.in_last = fin_last && i == s.len() - 1;
         while (!ok && t < 500) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk); #1;
            t++;
         end
         if (!ok) chk("byte_accept_timeout", 0, 1);
      end
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
   endtask
   task automatic start_run();
      n_clr = 0; n_dv = 0; n_nl = 0; n_sv = 0;
      lat = $urandom_range(0, 4);
   endtask
   task automatic finish_run(input string tag, input res_t e);
      int t = 0;
      while (!sum_valid && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk({tag, " done_seen"}, 64'(sum_valid), 1);
      chk({tag, " sum"}, sum, e.sum);
      chk({tag, " line_count"}, 64'(line_count), 64'(e.lines));
      chk({tag, " err"}, 64'(err), 64'(e.err));
      repeat (3) @(negedge clk);
      chk({tag, " sum_valid_pulses"}, 64'(n_sv), 1);
      chk({tag, " eng_clear_pulses"}, 64'(n_clr), 64'(e.clears));
      chk({tag, " drains"}, 64'(n_nl), 64'(e.drains));
      chk({tag, " data_strobes"}, 64'(n_dv), 64'(e.strobes));
      chk({tag, " idle_busy"}, 64'(busy), 0);
      chk({tag, " sum_hold"}, sum, e.sum);
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, " in_ready"}, 64'(bus.in_ready), 0);
      chk({tag, " eng_clear"}, 64'(eng_clear), 0);
      chk({tag, " eng_data_valid"}, 64'(eng_data_valid), 0);
      chk({tag, " eng_data"}, 64'(eng_data), 0);
      chk({tag, " eng_newline"}, 64'(eng_newline), 0);
      chk({tag, " sum"}, sum, 0);
      chk({tag, " sum_valid"}, 64'(sum_valid), 0);
      chk({tag, " line_count"}, 64'(line_count), 0);
      chk({tag, " busy"}, 64'(busy), 0);
      chk({tag, " err"}, 64'(err), 0);
   endtask
   initial begin
      vec_t tv[8];
      string four = "987654321111111\n811111111111119\n234234234234278\n818181911112111\n";
      string four_crlf = "987654321111111\r\n811111111111119\r\n234234234234278\r\n818181911112111\r\n";
      tv[0] = '{"987654321111111\n", 1'b0, 64'd987654321111, 1, 1, 1, 1'b0};
      tv[1] = '{four, 1'b0, 64'd3121910778619, 4, 4, 4, 1'b0};
      tv[2] = '{four_crlf, 1'b1, 64'd3121910778619, 4, 4, 4, 1'b0};
      tv[3] = '{"987654321111111\n\n811111111111119\n", 1'b0, 64'd1798765432230, 2, 3, 2, 1'b0};
      tv[4] = '{"987654321111111", 1'b1, 64'd987654321111, 1, 1, 1, 1'b0};
      tv[7] = '{"\r\n", 1'b0, 64'd0, 0, 1, 0, 1'b0};
`ifdef AOC3_LINE_CHECK_EN
      tv[5] = '{"98765432111111\n", 1'b0, 64'd0, 0, 1, 0, 1'b1};
      tv[6] = '{"11111111111111199\n", 1'b0, 64'd0, 0, 1, 0, 1'b1};
`else
      tv[5] = '{"98765432111111\n", 1'b0, 64'd987654321111, 1, 1, 1, 1'b0};
      tv[6] = '{"11111111111111199\n", 1'b0, 64'd111111111111, 1, 1, 1, 1'b0};
`endif
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
      bus.in_char = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         res_t e;
         start_run();
         send(tv[i].txt, tv[i].gaps, 1'b1);
         e = '{sum: tv[i].sum, lines: tv[i].lines, clears: tv[i].clears, drains: tv[i].drains,
               strobes: model(tv[i].txt).strobes, err: tv[i].err};
         finish_run($sformatf("vec%0d", i), e);
         @(posedge clk); #1;
      end
      // reset while the engine is still draining, then a fresh single-line run
      begin
         int t = 0;
         start_run();
         lat = 30;
         send("811111111111119\n", 1'b0, 1'b0);
         while (!eng_newline && t < 200) begin
            @(negedge clk);
            t++;
         end
         chk("drain_reached", 64'(eng_newline), 1);
         @(negedge clk);
         rst_n = 1'b0;
         @(posedge clk); #1;
         chk_zero("mid_drain_reset");
         repeat (2) @(posedge clk);
         #1;
         chk_zero("reset_hold");
         rst_n = 1'b1;
         @(posedge clk); #1;
         start_run();
         send("234234234234278\n", 1'b0, 1'b1);
         finish_run("after_reset", '{sum: 64'd434234234278, lines: 1, clears: 1, drains: 1, strobes: 15, err: 1'b0});
         @(posedge clk); #1;
      end
      for (int r = 0; r < 12; r++) begin
         string s = gen();
         bit g = 1'($urandom_range(0, 1));
         start_run();
         send(s, g, 1'b1);
         finish_run($sformatf("rand%0d", r), model(s));
         @(posedge clk); #1;
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
      $finish;
   end
endmodule
